// File: rtl/gs_pkg.sv
// Shared types and constants for the Gauss-Seidel sweep controller.
// GS_EARLY_STOP_EN (optional) enables the convergence early-stop path.
package gs_pkg;

    localparam int N        = 16;
    localparam int B_W      = 16;
    localparam int X_W      = 32;
    localparam int ITER_W   = 8;
    localparam int PIPE_LAT = 3;
    localparam logic [31:0] TOL = 32'd16;

    function automatic int slot_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int SLOT_W  = slot_w(N);
    localparam int DRAIN_W = slot_w(PIPE_LAT);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } gs_state_e;

endpackage

// File: rtl/gs_conv_check.sv
// Per-sweep convergence monitor: |x_new - x_old| against TOL with a sticky
// "some slot still moving" flag. Only built when GS_EARLY_STOP_EN is defined.
module gs_conv_check
    import gs_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              run_in,
    input  logic [SLOT_W-1:0] slot_in,
    input  logic [X_W-1:0]    x_new_in,
    input  logic [X_W-1:0]    x_old_in,
    output logic              conv_clear_out
);

    localparam int DW = X_W + 1;

    logic [DW-1:0] diff;
    logic [DW-1:0] mag;
    logic          over_now;
    logic          first_slot;
    logic          flag_q;

    // Sign-extend so the difference of two signed words cannot overflow.
    assign diff       = {x_new_in[X_W-1], x_new_in} - {x_old_in[X_W-1], x_old_in};
    assign mag        = diff[DW-1] ? (~diff + DW'(1)) : diff;
    assign over_now   = (mag >= DW'(TOL));
    assign first_slot = (slot_in == '0);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            flag_q <= 1'b0;
        end else if (run_in) begin
            flag_q <= first_slot ? over_now : (flag_q | over_now);
        end
    end

    assign conv_clear_out = first_slot ? !over_now : !(flag_q | over_now);

endmodule

// File: rtl/gs_sweep_controller.sv
// Loads 16 b words, times the programmed number of sweeps, drains the pipeline.
// Optional GS_EARLY_STOP_EN ends the run once a whole sweep is within TOL.
module gs_sweep_controller
    import gs_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              start_in,
    input  logic [ITER_W-1:0] iter_limit_in,
    input  logic              b_valid_in,
    input  logic [B_W-1:0]    b_data_in,
    output logic              b_ready_out,
    output logic              rf_en_out,
    output logic [B_W-1:0]    rf_b_out,
    input  logic [X_W-1:0]    x_new_in,
    input  logic [X_W-1:0]    x_old_in,
    output logic [SLOT_W-1:0] slot_out,
    output logic [ITER_W-1:0] iter_out,
    output logic              busy_out,
    output logic              done_out,
    output logic              err_out,
    input  logic              done_ack_in,
    output gs_state_e         state_dbg_out
);

    // b stream: a beat transfers when b_valid_in && b_ready_out on a rising edge;
    // b_ready_out is high for the whole of LOAD and the burst must not pause.

    gs_state_e          state, state_nxt;
    logic [SLOT_W-1:0]  beat_cnt;
    logic [SLOT_W-1:0]  slot_cnt;
    logic [ITER_W-1:0]  iter_cnt;
    logic [ITER_W-1:0]  limit_q;
    logic [DRAIN_W-1:0] drain_cnt;

    logic beat_acc, last_beat, load_abort, sweep_end, limit_hit, drain_last, early_stop;
    logic [ITER_W-1:0] iter_inc;

    assign beat_acc   = (state == ST_LOAD) && b_valid_in;
    assign last_beat  = beat_acc && (beat_cnt == SLOT_W'(N - 1));
    assign load_abort = (state == ST_LOAD) && !b_valid_in && (beat_cnt != '0);
    assign sweep_end  = (state == ST_RUN) && (slot_cnt == SLOT_W'(N - 1));
    assign iter_inc   = iter_cnt + ITER_W'(1);
    assign limit_hit  = (iter_inc == limit_q);
    assign drain_last = (drain_cnt == DRAIN_W'(PIPE_LAT - 1));

`ifdef GS_EARLY_STOP_EN
    logic conv_clear;

    gs_conv_check u_conv_check (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .run_in         (state == ST_RUN),
        .slot_in        (slot_cnt),
        .x_new_in       (x_new_in),
        .x_old_in       (x_old_in),
        .conv_clear_out (conv_clear)
    );

    assign early_stop = conv_clear && (iter_cnt != '0);
`else
    logic unused_x;
    assign unused_x   = ^{x_new_in, x_old_in};
    assign early_stop = 1'b0;
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (start_in) state_nxt = (iter_limit_in != '0) ? ST_LOAD : ST_DONE;
            ST_LOAD:  begin
                if (last_beat)       state_nxt = ST_RUN;
                else if (load_abort) state_nxt = ST_IDLE;
            end
            ST_RUN:   if (sweep_end && (limit_hit || early_stop)) state_nxt = ST_DRAIN;
            ST_DRAIN: if (drain_last) state_nxt = ST_DONE;
            ST_DONE:  if (done_ack_in) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            beat_cnt  <= '0;
            slot_cnt  <= '0;
            iter_cnt  <= '0;
            limit_q   <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_in) begin
                        limit_q   <= iter_limit_in;
                        beat_cnt  <= '0;
                        slot_cnt  <= '0;
                        iter_cnt  <= '0;
                        drain_cnt <= '0;
                    end
                end
                ST_LOAD:  if (beat_acc) beat_cnt <= beat_cnt + SLOT_W'(1);
                ST_RUN: begin
                    // Explicit wrap keeps N legal even if it is not a power of two.
                    slot_cnt <= sweep_end ? '0 : slot_cnt + SLOT_W'(1);
                    if (sweep_end) iter_cnt <= iter_inc;
                end
                ST_DRAIN: drain_cnt <= drain_cnt + DRAIN_W'(1);
                default: ;
            endcase
        end
    end

    assign b_ready_out   = (state == ST_LOAD);
    assign rf_en_out     = beat_acc;
    assign rf_b_out      = (state == ST_LOAD) ? b_data_in : '0;
    assign slot_out      = slot_cnt;
    assign iter_out      = iter_cnt;
    assign busy_out      = (state == ST_LOAD) || (state == ST_RUN) || (state == ST_DRAIN);
    assign done_out      = (state == ST_DONE);
    assign err_out       = load_abort;
    assign state_dbg_out = state;

endmodule

// File: doc/gs_sweep_controller.md
Name: gs_sweep_controller

Overview:
Sequencer for the 16-entry Gauss-Seidel b/x register file and its update datapath.
- Accepts a start command and loads 16 b coefficients into the register file as one contiguous burst.
- Then times a programmable number of 16-cycle sweeps, waits out the datapath pipeline latency, and reports completion.
- Sits between the host-side command/b-stream interface and the register file plus x-update pipeline.

Parameters:
N, 16, entries per sweep (register file depth); slot counter width is $clog2(N)
ITER_W, 8, width of iteration limit and iteration counter
PIPE_LAT, 3, cycles from the last slot of the final sweep until its x result is written back
B_W, 16, b coefficient width
X_W, 32, x word width (used only with the optional feature)
TOL, 32'd16, convergence tolerance in x LSBs (used only with the optional feature)

Ports:
clk_in  input  1  clock; all logic is on the rising edge
rst_in  input  1  reset, synchronous, active-high
start_in  input  1  single-cycle command; sampled only in IDLE
iter_limit_in  input  ITER_W  number of sweeps; captured on an accepted start
b_valid_in  input  1  b stream valid
b_data_in  input  B_W  b coefficient
b_ready_out  output  1  controller accepts b this cycle
rf_en_out  output  1  register file load enable (en_in of the register file)
rf_b_out  output  B_W  b word to the register file
x_new_in  input  X_W  updated x from the datapath (feature only)
x_old_in  input  X_W  previous x for the same slot (feature only)
slot_out  output  $clog2(N)  current slot index in RUN
iter_out  output  ITER_W  completed sweep count
busy_out  output  1  high in LOAD, RUN and DRAIN
done_out  output  1  high in DONE
err_out  output  1  one-cycle pulse when a load aborts
done_ack_in  input  1  host acknowledges completion

Behaviour:
- States: IDLE, LOAD, RUN, DRAIN, DONE.
- Reset values: state=IDLE and every output 0, including slot_out, iter_out and rf_b_out.
- IDLE:
  - start_in=1 with iter_limit_in!=0 -> LOAD. Captures iter_limit_in and clears the beat, slot and iteration counters.
  - start_in=1 with iter_limit_in==0 -> DONE directly, iter_out=0.
  - start_in is ignored in every other state.
- LOAD:
  - b_ready_out=1.
  - rf_en_out = b_valid_in && b_ready_out, combinational. rf_b_out = b_data_in, combinational.
  - Each accepted beat increments the beat count. On the N-th beat -> RUN in the next cycle.
  - The register file requires a contiguous enable burst. b_valid_in=0 after at least one beat has been accepted -> pulse err_out and go to IDLE.
  - b_valid_in=0 before the first beat is allowed; the controller waits.
- RUN:
  - slot_out counts 0..N-1 and wraps.
  - At the wrap from slot N-1, iter_out increments.
  - When iter_out+1 == limit at slot N-1 -> DRAIN.
  - Once in RUN the sweep length is exactly limit*N cycles.
- DRAIN: waits PIPE_LAT cycles, then -> DONE.
- DONE:
  - done_out=1 and is held.
  - done_ack_in=1 -> IDLE in the next cycle; iter_out holds its value until the next start.
- Reset mid-operation: rst_in=1 in any state returns to IDLE and all outputs to 0 in the next cycle. It takes priority over all other inputs.
- Simultaneous events:
  - Last LOAD beat together with start_in: start_in is ignored.
  - done_ack_in and start_in in the same cycle while in DONE: ack only; the start is not seen.
- Counters are modulo their width. Limit 255 with ITER_W=8 produces 255 sweeps with no overflow.

Optional Feature:
Macro GS_EARLY_STOP_EN.
- Defined:
  - In RUN, each slot compares |x_new_in - x_old_in| (signed, computed to X_W+1 bits) against TOL.
  - A sticky flag clears at slot 0 and is set if any slot has diff >= TOL.
  - At slot N-1, if the flag is clear (including the current slot) and iter_out >= 1 -> DRAIN early. iter_out still increments for that sweep.
- Undefined: x_new_in and x_old_in are unused and the comparator is not synthesised.

Decomposition:
- Shared package gs_pkg holds:
  - the state enum (IDLE/LOAD/RUN/DRAIN/DONE);
  - localparams N, B_W, X_W;
  - the slot index width function.
- One sub-module, gs_conv_check: the abs-diff compare plus sticky flag. It is instantiated only under GS_EARLY_STOP_EN.

Test Plan:
- Start, limit=2, 16 contiguous b beats 1..16 -> rf_en_out is high for exactly 16 cycles with rf_b_out=1..16. RUN lasts 32 cycles, DRAIN 3. done_out rises 51 cycles after the first beat; iter_out=2.
- b_valid_in dropped after 5 beats -> err_out pulses once, state returns to IDLE, busy_out=0. A following start with 16 beats completes normally.
- Start with limit=0 -> done_out=1 the next cycle, rf_en_out never asserts, iter_out=0.
- rst_in asserted mid-RUN at slot 7 of sweep 1 -> the next cycle all outputs are 0, state is IDLE, and start_in in that cycle is ignored.
- In DONE, done_ack_in and start_in asserted together -> IDLE with no new LOAD. A start the following cycle is then accepted.
- GS_EARLY_STOP_EN, limit=10, diff=0 on all slots from sweep 2 -> DONE after sweep 2 with iter_out=2. With diff=TOL on slot 15 every sweep -> runs all 10 sweeps.
